move_controller: RTL and testbench

Game-move sequencer for the Connect-4 datapath. Sits directly downstream of the debounced input stage: consumes its single-cycle `left_pulse` / `right_pulse` / `put_pulse` strobes and maintains:
- cursor column;
- per-column fill heights;
- whose turn it is.

It issues one board-write transaction per legal drop, then hands off to the win checker and waits for its verdict before the next turn.

---
 rtl/connect4_pkg.sv | 22 ++
 rtl/column_heights.sv | 40 ++++
 rtl/move_controller.sv | 178 +++++++++++++++++
 tb/tb_move_controller.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board geometry, player and move-state types,
// and the column/row index types used by the board memory and win checker.
package connect4_pkg;

    localparam int COLS = 7;
    localparam int ROWS = 6;
    localparam int CW   = $clog2(COLS);
    localparam int RW   = $clog2(ROWS + 1);

    typedef logic player_t;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        WRITE = 2'd1,
        CHECK = 2'd2,
        OVER  = 2'd3
    } move_state_t;

    typedef logic [CW-1:0] col_idx_t;
    typedef logic [RW-1:0] row_idx_t;

endpackage

// File: rtl/column_heights.sv
// Per-column fill heights: increment-by-index, synchronous clear, indexed read
// of one column height and a full flag for every column.
module column_heights #(
    parameter int COLS = connect4_pkg::COLS,
    parameter int ROWS = connect4_pkg::ROWS,
    parameter int CW   = $clog2(COLS),
    parameter int RW   = $clog2(ROWS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    input  logic [CW-1:0]   inc_col,
    input  logic [CW-1:0]   rd_col,
    output logic [RW-1:0]   rd_height,
    output logic [COLS-1:0] full
);
    import connect4_pkg::*;

    logic [RW-1:0] height_q [COLS];

    // Clear wins over increment so an aborted write never lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < COLS; i++) height_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < COLS; i++) height_q[i] <= '0;
        end else if (inc && !full[inc_col]) begin
            height_q[inc_col] <= height_q[inc_col] + 1'b1;
        end
    end

    always_comb begin
        full = '0;
        for (int i = 0; i < COLS; i++) full[i] = (height_q[i] == RW'(ROWS));
    end

    assign rd_height = height_q[rd_col];

endmodule

// File: rtl/move_controller.sv
// Connect-4 move sequencer: cursor, turn, drop legality, one board write per
// legal drop, then a win-checker handshake before the next turn.
module move_controller #(
    parameter int COLS = connect4_pkg::COLS,
    parameter int ROWS = connect4_pkg::ROWS,
    parameter int CW   = $clog2(COLS),
    parameter int RW   = $clog2(ROWS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          left_pulse,
    input  logic          right_pulse,
    input  logic          put_pulse,
    input  logic          new_game,
    output logic [CW-1:0] cursor_col,
    output logic          player,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [CW-1:0] wr_col,
    output logic [RW-1:0] wr_row,
    output logic          wr_player,
    output logic          check_req,
    input  logic          check_done,
    input  logic          check_win,
    output logic          col_full_err,
    output logic          game_over,
    output logic          draw,
    output logic          winner
);
    import connect4_pkg::*;

    localparam int            CELLS    = ROWS * COLS;
    localparam int            PW       = $clog2(CELLS + 1);
    localparam logic [CW-1:0] COL_MID  = CW'(COLS / 2);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    move_state_t     state_q, state_d;
    logic [PW-1:0]   piece_cnt_q, piece_cnt_d;
    logic [CW-1:0]   cursor_d, wr_col_d;
    logic [RW-1:0]   wr_row_d;
    player_t         player_d, wr_player_d, winner_d;
    logic            wr_valid_d, check_req_d, col_full_err_d;
    logic            game_over_d, draw_d;
    logic            write_hs;
    logic [RW-1:0]   cur_height;
    logic [COLS-1:0] col_full;

    // wr_valid is high for the whole WRITE state, so the handshake is state + ready.
    assign write_hs = (state_q == WRITE) && wr_ready && !new_game;

    column_heights #(
        .COLS (COLS),
        .ROWS (ROWS),
        .CW   (CW),
        .RW   (RW)
    ) u_heights (
        .clk       (clk),
        .rst       (rst),
        .clr       (new_game),
        .inc       (write_hs),
        .inc_col   (wr_col),
        .rd_col    (cursor_col),
        .rd_height (cur_height),
        .full      (col_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= PLAY;
            piece_cnt_q  <= '0;
            cursor_col   <= COL_MID;
            player       <= 1'b0;
            wr_valid     <= 1'b0;
            wr_col       <= '0;
            wr_row       <= '0;
            wr_player    <= 1'b0;
            check_req    <= 1'b0;
            col_full_err <= 1'b0;
            game_over    <= 1'b0;
            draw         <= 1'b0;
            winner       <= 1'b0;
        end else begin
            state_q      <= state_d;
            piece_cnt_q  <= piece_cnt_d;
            cursor_col   <= cursor_d;
            player       <= player_d;
            wr_valid     <= wr_valid_d;
            wr_col       <= wr_col_d;
            wr_row       <= wr_row_d;
            wr_player    <= wr_player_d;
            check_req    <= check_req_d;
            col_full_err <= col_full_err_d;
            game_over    <= game_over_d;
            draw         <= draw_d;
            winner       <= winner_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        piece_cnt_d    = piece_cnt_q;
        cursor_d       = cursor_col;
        player_d       = player;
        wr_valid_d     = wr_valid;
        wr_col_d       = wr_col;
        wr_row_d       = wr_row;
        wr_player_d    = wr_player;
        check_req_d    = 1'b0;
        col_full_err_d = 1'b0;
        game_over_d    = game_over;
        draw_d         = draw;
        winner_d       = winner;

        if (new_game) begin
            state_d     = PLAY;
            piece_cnt_d = '0;
            cursor_d    = COL_MID;
            player_d    = 1'b0;
            wr_valid_d  = 1'b0;
            game_over_d = 1'b0;
            draw_d      = 1'b0;
            winner_d    = 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (left_pulse) begin
                        cursor_d = (cursor_col == '0) ? COL_LAST : cursor_col - 1'b1;
                    end else if (right_pulse) begin
                        cursor_d = (cursor_col == COL_LAST) ? '0 : cursor_col + 1'b1;
                    end else if (put_pulse) begin
                        if (col_full[cursor_col]) begin
                            col_full_err_d = 1'b1;
                        end else begin
                            wr_col_d    = cursor_col;
                            wr_row_d    = cur_height;
                            wr_player_d = player;
                            wr_valid_d  = 1'b1;
                            state_d     = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (write_hs) begin
                        wr_valid_d  = 1'b0;
                        piece_cnt_d = piece_cnt_q + 1'b1;
                        check_req_d = 1'b1;
                        state_d     = CHECK;
                    end
                end
                CHECK: begin
                    // piece_cnt already counts the piece under test here.
                    if (check_done) begin
                        if (check_win) begin
                            game_over_d = 1'b1;
                            draw_d      = 1'b0;
                            winner_d    = wr_player;
                            state_d     = OVER;
                        end else if (piece_cnt_q == PW'(CELLS)) begin
                            game_over_d = 1'b1;
                            draw_d      = 1'b1;
                            state_d     = OVER;
                        end else begin
                            player_d = ~player;
                            state_d  = PLAY;
                        end
                    end
                end
                OVER: begin
                    game_over_d = 1'b1;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_controller.sv
// Self-checking bench for move_controller: cursor vector table, drop sequences
// with a write scoreboard, full column, win, draw, abort and mid-check reset.
module tb_move_controller;

    localparam int COLS = 7;
    localparam int ROWS = 6;
    localparam int CW   = 3;
    localparam int RW   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          left_pulse = 1'b0, right_pulse = 1'b0, put_pulse = 1'b0, new_game = 1'b0;
    logic          wr_ready = 1'b0, check_done = 1'b0, check_win = 1'b0;
    logic [CW-1:0] cursor_col, wr_col;
    logic [RW-1:0] wr_row;
    logic          player, wr_valid, wr_player, check_req, col_full_err;
    logic          game_over, draw, winner;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic          ply;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic l;
        logic r;
        logic p;
        int   exp_col;
        int   exp_wv;
    } cur_vec_t;
    cur_vec_t vecs[8];

    int m_h[COLS];
    int m_player, m_cnt, m_cursor;

    move_controller dut (
        .clk          (clk),
        .rst          (rst),
        .left_pulse   (left_pulse),
        .right_pulse  (right_pulse),
        .put_pulse    (put_pulse),
        .new_game     (new_game),
        .cursor_col   (cursor_col),
        .player       (player),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_col       (wr_col),
        .wr_row       (wr_row),
        .wr_player    (wr_player),
        .check_req    (check_req),
        .check_done   (check_done),
        .check_win    (check_win),
        .col_full_err (col_full_err),
        .game_over    (game_over),
        .draw         (draw),
        .winner       (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int i = 0; i < COLS; i++) m_h[i] = 0;
        m_player = 0;
        m_cnt    = 0;
        m_cursor = 3;
    endtask

    // Write scoreboard: a handshake about to complete must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && wr_valid && wr_ready && !new_game) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("sb_wr_col", int'(wr_col), int'(e.col));
                chk("sb_wr_row", int'(wr_row), int'(e.row));
                chk("sb_wr_player", int'(wr_player), int'(e.ply));
            end
        end
    end

    task automatic pulse_right();
        right_pulse = 1'b1;
        tick();
        right_pulse = 1'b0;
        m_cursor = (m_cursor + 1) % COLS;
    endtask

    task automatic move_to(input int target);
        for (int i = 0; i < COLS && m_cursor != target; i++) pulse_right();
        chk("move_to_cursor", int'(cursor_col), target);
    endtask

    task automatic drop(input int stall, input bit win);
        wr_t e;
        e.col = CW'(m_cursor);
        e.row = RW'(m_h[m_cursor]);
        e.ply = m_player[0];
        sb.push_back(e);
        put_pulse = 1'b1;
        tick();
        put_pulse = 1'b0;
        chk("wr_valid_after_put", int'(wr_valid), 1);
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("stall_wr_valid", int'(wr_valid), 1);
            chk("stall_wr_col", int'(wr_col), int'(e.col));
            chk("stall_wr_row", int'(wr_row), int'(e.row));
            chk("stall_wr_player", int'(wr_player), int'(e.ply));
        end
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        chk("check_req_pulse", int'(check_req), 1);
        chk("wr_valid_dropped", int'(wr_valid), 0);
        m_h[m_cursor]++;
        m_cnt++;
        check_done = 1'b1;
        check_win  = win;
        tick();
        check_done = 1'b0;
        check_win  = 1'b0;
        chk("check_req_single", int'(check_req), 0);
        if (win) begin
            chk("win_game_over", int'(game_over), 1);
            chk("win_winner", int'(winner), m_player);
            chk("win_draw", int'(draw), 0);
        end else if (m_cnt == ROWS * COLS) begin
            chk("draw_game_over", int'(game_over), 1);
            chk("draw_flag", int'(draw), 1);
        end else begin
            m_player ^= 1;
            chk("turn_player", int'(player), m_player);
            chk("turn_game_over", int'(game_over), 0);
        end
    endtask

    task automatic start_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        reset_model();
        chk("ng_cursor", int'(cursor_col), 3);
        chk("ng_player", int'(player), 0);
        chk("ng_game_over", int'(game_over), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cursor"}, int'(cursor_col), 3);
        chk({tag, "_player"}, int'(player), 0);
        chk({tag, "_wr_valid"}, int'(wr_valid), 0);
        chk({tag, "_wr_col"}, int'(wr_col), 0);
        chk({tag, "_wr_row"}, int'(wr_row), 0);
        chk({tag, "_wr_player"}, int'(wr_player), 0);
        chk({tag, "_check_req"}, int'(check_req), 0);
        chk({tag, "_col_full_err"}, int'(col_full_err), 0);
        chk({tag, "_game_over"}, int'(game_over), 0);
        chk({tag, "_draw"}, int'(draw), 0);
        chk({tag, "_winner"}, int'(winner), 0);
    endtask

    initial begin
        //            l     r     p     col wv
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1, 0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 0, 0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 6, 0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 0, 0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 6, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 0, 0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 6, 0};

        reset_model();
        #12;
        check_reset_outputs("reset");
        #10 rst = 1'b1;
        tick();
        check_reset_outputs("post_reset");

        foreach (vecs[i]) begin
            left_pulse  = vecs[i].l;
            right_pulse = vecs[i].r;
            put_pulse   = vecs[i].p;
            tick();
            left_pulse  = 1'b0;
            right_pulse = 1'b0;
            put_pulse   = 1'b0;
            chk($sformatf("vec%0d_cursor", i), int'(cursor_col), vecs[i].exp_col);
            chk($sformatf("vec%0d_wr_valid", i), int'(wr_valid), vecs[i].exp_wv);
        end
        m_cursor = 6;
        move_to(3);

        drop(5, 1'b0);
        for (int k = 0; k < 5; k++) drop(0, 1'b0);

        put_pulse = 1'b1;
        tick();
        put_pulse = 1'b0;
        chk("full_err_pulse", int'(col_full_err), 1);
        chk("full_no_write", int'(wr_valid), 0);
        tick();
        chk("full_err_single", int'(col_full_err), 0);
        chk("full_player_same", int'(player), m_player);
        chk("full_still_no_write", int'(wr_valid), 0);

        check_done = 1'b1;
        check_win  = 1'b1;
        tick();
        check_done = 1'b0;
        check_win  = 1'b0;
        chk("stray_done_game_over", int'(game_over), 0);
        chk("stray_done_player", int'(player), m_player);

        start_new_game();
        drop(0, 1'b0);
        drop(0, 1'b1);
        left_pulse = 1'b1;
        tick();
        left_pulse = 1'b0;
        put_pulse  = 1'b1;
        tick();
        put_pulse  = 1'b0;
        chk("over_cursor_frozen", int'(cursor_col), 3);
        chk("over_no_write", int'(wr_valid), 0);
        chk("over_still_over", int'(game_over), 1);
        chk("over_winner_kept", int'(winner), 1);

        start_new_game();
        for (int c = 0; c < COLS; c++) begin
            move_to(c);
            for (int r = 0; r < ROWS; r++) drop((r == 0) ? 1 : 0, 1'b0);
        end
        put_pulse = 1'b1;
        tick();
        put_pulse = 1'b0;
        chk("draw_no_write", int'(wr_valid), 0);
        chk("draw_kept", int'(draw), 1);

        start_new_game();
        drop(0, 1'b0);
        move_to(5);
        put_pulse = 1'b1;
        tick();
        put_pulse = 1'b0;
        chk("abort_wr_valid_pre", int'(wr_valid), 1);
        wr_ready = 1'b1;
        new_game = 1'b1;
        tick();
        wr_ready = 1'b0;
        new_game = 1'b0;
        reset_model();
        chk("abort_wr_valid", int'(wr_valid), 0);
        chk("abort_check_req", int'(check_req), 0);
        chk("abort_cursor", int'(cursor_col), 3);
        chk("abort_player", int'(player), 0);
        tick();
        chk("abort_no_late_check", int'(check_req), 0);
        move_to(5);
        drop(0, 1'b0);

        begin
            wr_t e;
            e.col = CW'(m_cursor);
            e.row = RW'(m_h[m_cursor]);
            e.ply = m_player[0];
            sb.push_back(e);
        end
        put_pulse = 1'b1;
        tick();
        put_pulse = 1'b0;
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;
        chk("rst_in_check_req", int'(check_req), 1);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("mid_check_rst");
        tick();
        rst = 1'b1;
        reset_model();
        tick();
        check_reset_outputs("after_rst");
        move_to(5);
        drop(0, 1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
